hazard_track_unit: RTL and testbench
====================================

Name: hazard_track_unit

Overview:
- Producer side of operand forwarding: tracks destination tags of in-flight instructions through the EX, MEM and WB stages.
- Drives the forwarding-source signals consumed by the forwarding unit: wr_add_alu/wb_alu from the EX/MEM pipe and wr_add_mem/wb_mem from the MEM/WB pipe.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble.
- Freezes the pipe while memory is busy and handles branch flush.
- Sits beside the decode stage; carries control tags only, no datapath.

Parameters:
ADDR_W, 3, register-address width
CNT_W, 16, stall-counter width

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  reset; one clock; asynchronous, active-high
id_valid  in  1  decode stage holds a real instruction
id_src  in  ADDR_W  source register of decode instruction
id_dst  in  ADDR_W  destination register, also read as second operand
id_uses_src  in  1  instruction reads id_src
id_uses_dst  in  1  instruction reads id_dst
id_wb  in  1  instruction writes back
id_mem_read  in  1  instruction is a load
flush  in  1  branch taken: discard decode instruction
mem_busy  in  1  memory stage cannot complete this cycle
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID register
bubble_idex  out  1  ID/EX loads a NOP
wr_add_alu  out  ADDR_W  EX/MEM destination
wb_alu  out  1  EX/MEM will write back (valid and wb)
wr_add_mem  out  ADDR_W  MEM/WB destination
wb_mem  out  1  MEM/WB will write back
state  out  2  00 RUN, 01 BUBBLE, 10 FREEZE
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Tag registers: EX {valid, dst, wb, mem_read}, MEM {valid, dst, wb}, WB {valid, dst, wb}.
- wr_add_alu and wb_alu are driven from the MEM tag. wr_add_mem and wb_mem are driven from the WB tag.
- wb_* = valid AND wb. An address output holds its last value when its wb_* is 0.
- Reset (async, any time, including mid-freeze or mid-bubble):
  - all tags cleared to 0; state RUN; stall_count 0.
  - stall_pc, stall_ifid, bubble_idex read 0 while rst is high.
- Load-use hazard (combinational) = id_valid AND EX.valid AND EX.mem_read AND EX.wb AND ((id_uses_src AND id_src==EX.dst) OR (id_uses_dst AND id_dst==EX.dst)).
- Priority per cycle, highest first:
  1. mem_busy: stall_pc=stall_ifid=1, bubble_idex=0. All tags hold. Next state FREEZE. stall_count +1.
  2. flush: stall_pc=stall_ifid=0, bubble_idex=1. EX gets an invalid tag; MEM<=EX, WB<=MEM. Next state RUN. Counter unchanged.
  3. hazard: stall_pc=stall_ifid=1, bubble_idex=1. EX gets an invalid tag; MEM<=EX, WB<=MEM. Next state BUBBLE. stall_count +1.
  4. otherwise: all stall outputs 0. EX<={id_valid, id_dst, id_wb, id_mem_read}; MEM<=EX, WB<=MEM. Next state RUN.
- Stall outputs are combinational and take effect in the same cycle the condition appears.
- Tags and state update at the edge ending that cycle.
- Latency: a load entering EX at edge k is visible on wb_alu after edge k+1 and on wb_mem after edge k+2.
- BUBBLE lasts exactly one cycle. The hazard cannot retrigger because EX is invalid. The dependent instruction issues in the following cycle and takes its operand from the mem pipe.
- FREEZE persists while mem_busy is 1. The cycle after mem_busy falls is evaluated normally, and a pending hazard is still detected then.
- A tag comparison never matches an invalid EX entry; a register-0 destination is treated like any other.
- stall_count saturates at all-ones and does not wrap.
- state encoding 11 is unused; if ever reached, the next state is RUN.

Test Plan:
- Reset mid-freeze: mem_busy=1 for 3 cycles, assert rst asynchronously between edges → outputs clear immediately, state=00, stall_count=0, wb_alu=wb_mem=0.
- Load-use, src match: load r2 (id_mem_read=1, id_dst=2), then add with id_src=2 → one cycle with stall_pc=stall_ifid=bubble_idex=1 and state=01. Next cycle the add issues; wb_mem=1 with wr_add_mem=2 while the add is in EX; stall_count=1.
- Load followed by an independent instruction (id_src=4, id_dst=5) → no stall. Pipeline tags advance: wr_add_alu=2 one cycle later, wr_add_mem=2 two cycles later.
- Hazard present together with flush=1 → no stall, bubble_idex=1, state stays 00, stall_count unchanged.
- mem_busy held 4 cycles with a load in EX and a dependent instruction in ID:
  - during busy: tags frozen, bubble_idex=0, state=10.
  - cycle after busy: the hazard bubble is taken.
  - stall_count=5.
- Saturation: CNT_W=4, hold mem_busy for 20 cycles → stall_count stops at 15.

Source files
------------

// File: rtl/hazard_track_unit.sv
// Control-tag pipeline beside decode: tracks EX/MEM/WB destinations for forwarding,
// inserts a single bubble on load-use, freezes on memory busy, and squashes on flush.
module hazard_track_unit #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_src,
  input  logic [ADDR_W-1:0] id_dst,
  input  logic              id_uses_src,
  input  logic              id_uses_dst,
  input  logic              id_wb,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              mem_busy,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic [ADDR_W-1:0] wr_add_alu,
  output logic              wb_alu,
  output logic [ADDR_W-1:0] wr_add_mem,
  output logic              wb_mem,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_BUBBLE = 2'b01;
  localparam logic [1:0] ST_FREEZE = 2'b10;

  logic              ex_valid_q, ex_valid_d;
  logic [ADDR_W-1:0] ex_dst_q, ex_dst_d;
  logic              ex_wb_q, ex_wb_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_dst_q, mem_dst_d;
  logic              mem_wb_q, mem_wb_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_dst_q, wb_dst_d;
  logic              wb_wb_q, wb_wb_d;
  logic [ADDR_W-1:0] wr_add_alu_q, wr_add_alu_d;
  logic [ADDR_W-1:0] wr_add_mem_q, wr_add_mem_d;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hazard;
  logic              stall_event;

  // Only a valid, writing load in EX can create a hazard forwarding cannot cover.
  assign hazard = id_valid && ex_valid_q && ex_mem_read_q && ex_wb_q &&
                  ((id_uses_src && (id_src == ex_dst_q)) ||
                   (id_uses_dst && (id_dst == ex_dst_q)));

  assign stall_event = mem_busy || (!flush && hazard);

  assign stall_pc    = !rst && stall_event;
  assign stall_ifid  = !rst && stall_event;
  assign bubble_idex = !rst && !mem_busy && (flush || hazard);

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_dst_d      = ex_dst_q;
    ex_wb_d       = ex_wb_q;
    ex_mem_read_d = ex_mem_read_q;
    mem_valid_d   = mem_valid_q;
    mem_dst_d     = mem_dst_q;
    mem_wb_d      = mem_wb_q;
    wb_valid_d    = wb_valid_q;
    wb_dst_d      = wb_dst_q;
    wb_wb_d       = wb_wb_q;
    wr_add_alu_d  = wr_add_alu_q;
    wr_add_mem_d  = wr_add_mem_q;
    state_d       = ST_RUN;
    cnt_d         = cnt_q;

    if (mem_busy) begin
      state_d = ST_FREEZE;
    end else begin
      if (flush || hazard) begin
        ex_valid_d    = 1'b0;
        ex_dst_d      = '0;
        ex_wb_d       = 1'b0;
        ex_mem_read_d = 1'b0;
      end else begin
        ex_valid_d    = id_valid;
        ex_dst_d      = id_dst;
        ex_wb_d       = id_wb;
        ex_mem_read_d = id_mem_read;
      end
      mem_valid_d = ex_valid_q;
      mem_dst_d   = ex_dst_q;
      mem_wb_d    = ex_wb_q;
      wb_valid_d  = mem_valid_q;
      wb_dst_d    = mem_dst_q;
      wb_wb_d     = mem_wb_q;
      // Address outputs only follow tags that actually write back.
      if (ex_valid_q && ex_wb_q) wr_add_alu_d = ex_dst_q;
      if (mem_valid_q && mem_wb_q) wr_add_mem_d = mem_dst_q;
      if (!flush && hazard) state_d = ST_BUBBLE;
    end

    if (stall_event && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_dst_q      <= '0;
      ex_wb_q       <= 1'b0;
      ex_mem_read_q <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_dst_q     <= '0;
      mem_wb_q      <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_dst_q      <= '0;
      wb_wb_q       <= 1'b0;
      wr_add_alu_q  <= '0;
      wr_add_mem_q  <= '0;
      state_q       <= ST_RUN;
      cnt_q         <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_dst_q      <= ex_dst_d;
      ex_wb_q       <= ex_wb_d;
      ex_mem_read_q <= ex_mem_read_d;
      mem_valid_q   <= mem_valid_d;
      mem_dst_q     <= mem_dst_d;
      mem_wb_q      <= mem_wb_d;
      wb_valid_q    <= wb_valid_d;
      wb_dst_q      <= wb_dst_d;
      wb_wb_q       <= wb_wb_d;
      wr_add_alu_q  <= wr_add_alu_d;
      wr_add_mem_q  <= wr_add_mem_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
    end
  end

  assign wr_add_alu  = wr_add_alu_q;
  assign wb_alu      = mem_valid_q && mem_wb_q;
  assign wr_add_mem  = wr_add_mem_q;
  assign wb_mem      = wb_valid_q && wb_wb_q;
  assign state       = state_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_track_unit.sv
// Bench for hazard_track_unit: directed scenarios plus random traffic checked
// against an instruction-level pipeline model.
module tb_hazard_track_unit;

  localparam int AW = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_src, id_uses_dst, id_wb, id_mem_read, flush, mem_busy;
  logic [AW-1:0] id_src, id_dst;
  logic stall_pc, stall_ifid, bubble_idex, wb_alu, wb_mem;
  logic [AW-1:0] wr_add_alu, wr_add_mem;
  logic [1:0] state;
  logic [CW-1:0] stall_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_track_unit #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_dst(id_dst),
    .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst), .id_wb(id_wb),
    .id_mem_read(id_mem_read), .flush(flush), .mem_busy(mem_busy),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .wr_add_alu(wr_add_alu), .wb_alu(wb_alu), .wr_add_mem(wr_add_mem), .wb_mem(wb_mem),
    .state(state), .stall_count(stall_count)
  );

  // Reference model: a list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit      valid;
    int      dst;
    bit      wb;
    bit      load;
  } instr_t;

  instr_t pipe[3];
  int m_alu_addr, m_mem_addr, m_cnt, m_state;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    m_alu_addr = 0; m_mem_addr = 0; m_cnt = 0; m_state = 0;
  endfunction

  function automatic bit m_hazard();
    return id_valid && pipe[0].valid && pipe[0].load && pipe[0].wb &&
           ((id_uses_src && int'(id_src) == pipe[0].dst) ||
            (id_uses_dst && int'(id_dst) == pipe[0].dst));
  endfunction

  function automatic bit m_stall();
    return mem_busy || (!flush && m_hazard());
  endfunction

  function automatic bit m_bubble();
    return !mem_busy && (flush || m_hazard());
  endfunction

  function automatic void model_step();
    bit hz;
    hz = m_hazard();
    if (m_stall()) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    if (mem_busy) begin
      m_state = 2;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (flush || hz) pipe[0] = '{0, 0, 0, 0};
      else pipe[0] = '{id_valid, int'(id_dst), id_wb, id_mem_read};
      m_state = (!flush && hz) ? 1 : 0;
      if (pipe[1].valid && pipe[1].wb) m_alu_addr = pipe[1].dst;
      if (pipe[2].valid && pipe[2].wb) m_mem_addr = pipe[2].dst;
    end
  endfunction

  task automatic drive(input bit v, input int src, input int dst, input bit us, input bit ud,
                       input bit wb, input bit ld, input bit fl, input bit busy);
    id_valid = v; id_src = AW'(src); id_dst = AW'(dst); id_uses_src = us; id_uses_dst = ud;
    id_wb = wb; id_mem_read = ld; flush = fl; mem_busy = busy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset_dut();
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0); tick();
    drive(1, 0, 6, 0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    n_cmp++; if (state !== 2'b10 || stall_pc !== 1'b1) begin n_fail++;
      $display("FAIL reset_prefreeze state=%b stall_pc=%b exp 10/1", state, stall_pc); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({stall_pc, stall_ifid, bubble_idex} !== 3'b000) begin n_fail++;
      $display("FAIL reset_stall got=%b exp=000", {stall_pc, stall_ifid, bubble_idex}); end
    n_cmp++; if (state !== 2'b00) begin n_fail++;
      $display("FAIL reset_state got=%b exp=00", state); end
    n_cmp++; if (stall_count !== '0) begin n_fail++;
      $display("FAIL reset_count got=%0d exp=0", stall_count); end
    n_cmp++; if ({wb_alu, wb_mem} !== 2'b00) begin n_fail++;
      $display("FAIL reset_wb got=%b exp=00", {wb_alu, wb_mem}); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_load_use_src();
    reset_dut();
    drive(1, 0, 2, 0, 0, 1, 1, 0, 0); tick();
    drive(1, 2, 3, 1, 0, 1, 0, 0, 0);
    n_cmp++; if ({stall_pc, stall_ifid, bubble_idex} !== 3'b111) begin n_fail++;
      $display("FAIL lu_stall got=%b exp=111", {stall_pc, stall_ifid, bubble_idex}); end
    tick();
    drive(1, 2, 3, 1, 0, 1, 0, 0, 0);
    n_cmp++; if (state !== 2'b01 || stall_pc !== 1'b0) begin n_fail++;
      $display("FAIL lu_bubble state=%b stall_pc=%b exp 01/0", state, stall_pc); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (wb_mem !== 1'b1 || wr_add_mem !== 3'd2) begin n_fail++;
      $display("FAIL lu_fwd wb_mem=%b wr_add_mem=%0d exp 1/2", wb_mem, wr_add_mem); end
    n_cmp++; if (stall_count !== 4'd1 || state !== 2'b00) begin n_fail++;
      $display("FAIL lu_count cnt=%0d state=%b exp 1/00", stall_count, state); end
  endtask

  task automatic test_independent();
    reset_dut();
    drive(1, 0, 2, 0, 0, 1, 1, 0, 0); tick();
    drive(1, 4, 5, 1, 1, 1, 0, 0, 0);
    n_cmp++; if ({stall_pc, stall_ifid, bubble_idex} !== 3'b000) begin n_fail++;
      $display("FAIL ind_stall got=%b exp=000", {stall_pc, stall_ifid, bubble_idex}); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (wb_alu !== 1'b1 || wr_add_alu !== 3'd2) begin n_fail++;
      $display("FAIL ind_alu wb_alu=%b wr_add_alu=%0d exp 1/2", wb_alu, wr_add_alu); end
    tick();
    n_cmp++; if (wb_mem !== 1'b1 || wr_add_mem !== 3'd2 || wr_add_alu !== 3'd5) begin n_fail++;
      $display("FAIL ind_mem wb_mem=%b wr_add_mem=%0d wr_add_alu=%0d exp 1/2/5",
               wb_mem, wr_add_mem, wr_add_alu); end
  endtask

  task automatic test_flush();
    reset_dut();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
    drive(1, 7, 0, 0, 1, 1, 0, 1, 0);
    n_cmp++; if ({stall_pc, stall_ifid, bubble_idex} !== 3'b001) begin n_fail++;
      $display("FAIL flush_out got=%b exp=001", {stall_pc, stall_ifid, bubble_idex}); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (state !== 2'b00 || stall_count !== 4'd0) begin n_fail++;
      $display("FAIL flush_state state=%b cnt=%0d exp 00/0", state, stall_count); end
  endtask

  task automatic test_freeze();
    reset_dut();
    drive(1, 0, 4, 0, 0, 1, 1, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 4, 1, 1, 0, 1, 0, 0, 1);
      n_cmp++; if ({stall_pc, stall_ifid, bubble_idex} !== 3'b110) begin n_fail++;
        $display("FAIL frz_out cyc=%0d got=%b exp=110", i, {stall_pc, stall_ifid, bubble_idex}); end
      tick();
    end
    n_cmp++; if (state !== 2'b10 || wb_alu !== 1'b0) begin n_fail++;
      $display("FAIL frz_state state=%b wb_alu=%b exp 10/0", state, wb_alu); end
    drive(1, 4, 1, 1, 0, 1, 0, 0, 0);
    n_cmp++; if ({stall_pc, stall_ifid, bubble_idex} !== 3'b111) begin n_fail++;
      $display("FAIL frz_after got=%b exp=111", {stall_pc, stall_ifid, bubble_idex}); end
    tick();
    n_cmp++; if (stall_count !== 4'd5 || state !== 2'b01) begin n_fail++;
      $display("FAIL frz_count cnt=%0d state=%b exp 5/01", stall_count, state); end
  endtask

  task automatic test_saturation();
    reset_dut();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (20) tick();
    n_cmp++; if (stall_count !== 4'd15) begin n_fail++;
      $display("FAIL sat_count got=%0d exp=15", stall_count); end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) reset_dut();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      n_cmp++; if (stall_pc !== m_stall() || stall_ifid !== m_stall()) begin n_fail++;
        $display("FAIL rnd_stall cyc=%0d got=%b%b exp=%b", i, stall_pc, stall_ifid, m_stall()); end
      n_cmp++; if (bubble_idex !== m_bubble()) begin n_fail++;
        $display("FAIL rnd_bubble cyc=%0d got=%b exp=%b", i, bubble_idex, m_bubble()); end
      n_cmp++; if (wb_alu !== (pipe[1].valid && pipe[1].wb) || int'(wr_add_alu) != m_alu_addr) begin
        n_fail++;
        $display("FAIL rnd_alu cyc=%0d got=%b/%0d exp=%b/%0d", i, wb_alu, wr_add_alu,
                 pipe[1].valid && pipe[1].wb, m_alu_addr); end
      n_cmp++; if (wb_mem !== (pipe[2].valid && pipe[2].wb) || int'(wr_add_mem) != m_mem_addr) begin
        n_fail++;
        $display("FAIL rnd_mem cyc=%0d got=%b/%0d exp=%b/%0d", i, wb_mem, wr_add_mem,
                 pipe[2].valid && pipe[2].wb, m_mem_addr); end
      n_cmp++; if (int'(state) != m_state || int'(stall_count) != m_cnt) begin n_fail++;
        $display("FAIL rnd_state cyc=%0d got=%0d/%0d exp=%0d/%0d", i, state, stall_count,
                 m_state, m_cnt); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_load_use_src();
    test_independent();
    test_flush();
    test_freeze();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
